// File: rtl/serial_tx_sched.sv
// Round-robin scheduler that shares one serial TX link among NUM_REQ requesters.
// Per packet: grant, stream words into the TX FIFO, strobe the word count, await ack or timeout.
module serial_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int CMD_NUM_WID = 6,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*CMD_NUM_WID-1:0] req_num_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]             req_vld_i,
  output logic [NUM_REQ-1:0]             req_rdy_o,
  output logic [NUM_REQ-1:0]             req_done_o,
  output logic [NUM_REQ-1:0]             req_err_o,
  output logic                           tx_valid_o,
  output logic [DATA_WIDTH-1:0]          tx_data_o,
  output logic                           tx_data_num_en_o,
  output logic [CMD_NUM_WID-1:0]         tx_data_num_o,
  input  logic                           tx_ack_i,
  output logic                           busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t                 state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          grant;
  logic [IW-1:0]          arb_idx;
  logic                   arb_hit;
  logic [CMD_NUM_WID-1:0] num_q;
  logic [CMD_NUM_WID-1:0] word_cnt;
  logic [TW-1:0]          to_cnt;
  logic [NUM_REQ-1:0]     grant_oh;
  logic                   hs;

  // First pending request at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned k;
    k       = 0;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!arb_hit && req_i[k]) begin
        arb_hit = 1'b1;
        arb_idx = IW'(k);
      end
    end
  end

  always_comb begin
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
  end

  assign req_rdy_o = (state == ST_LOAD) ? grant_oh : '0;
  assign hs        = (state == ST_LOAD) && req_vld_i[grant];
  assign busy_o    = (state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      rr_ptr           <= '0;
      grant            <= '0;
      num_q            <= '0;
      word_cnt         <= '0;
      to_cnt           <= '0;
      req_done_o       <= '0;
      req_err_o        <= '0;
      tx_valid_o       <= 1'b0;
      tx_data_o        <= '0;
      tx_data_num_en_o <= 1'b0;
      tx_data_num_o    <= '0;
    end else begin
      tx_valid_o       <= 1'b0;
      tx_data_num_en_o <= 1'b0;
      req_done_o       <= '0;
      req_err_o        <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_hit) begin
            grant    <= arb_idx;
            num_q    <= req_num_i[arb_idx*CMD_NUM_WID +: CMD_NUM_WID];
            word_cnt <= '0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (hs) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= req_data_i[grant*DATA_WIDTH +: DATA_WIDTH];
            if (word_cnt == num_q) begin
              word_cnt <= '0;
              state    <= ST_KICK;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        ST_KICK: begin
          tx_data_num_en_o <= 1'b1;
          tx_data_num_o    <= num_q;
          to_cnt           <= '0;
          state            <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Ack takes precedence over a timeout landing in the same cycle.
          if (tx_ack_i) begin
            req_done_o <= grant_oh;
            state      <= ST_DONE;
          end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
            req_err_o <= grant_oh;
            state     <= ST_ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_sched.sv
// Directed self-checking bench for serial_tx_sched: single packet, round-robin,
// backpressure, ack timeout, mid-load reset and word-count corners.
module tb_serial_tx_sched;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int NW = 6;
  localparam int TO = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req;
  logic [NR*NW-1:0]   req_num;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_vld;
  logic [NR-1:0]      req_rdy;
  logic [NR-1:0]      req_done;
  logic [NR-1:0]      req_err;
  logic               tx_valid;
  logic [DW-1:0]      tx_data;
  logic               tx_num_en;
  logic [NW-1:0]      tx_num;
  logic               tx_ack;
  logic               busy;

  serial_tx_sched #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .CMD_NUM_WID(NW),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_i           (req),
    .req_num_i       (req_num),
    .req_data_i      (req_data),
    .req_vld_i       (req_vld),
    .req_rdy_o       (req_rdy),
    .req_done_o      (req_done),
    .req_err_o       (req_err),
    .tx_valid_o      (tx_valid),
    .tx_data_o       (tx_data),
    .tx_data_num_en_o(tx_num_en),
    .tx_data_num_o   (tx_num),
    .tx_ack_i        (tx_ack),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int nums[NR];

  // Link-side monitor, sampled shortly after each rising edge.
  logic [DW-1:0] wq[$];
  int cyc = 0, last_v = 0, strobe_cyc = 0, n_strobe = 0, wr_at_strobe = 0;
  logic [NW-1:0] strobe_num;
  always @(posedge clk) begin
    #2;
    cyc++;
    if (tx_valid) begin
      wq.push_back(tx_data);
      last_v = cyc;
    end
    if (tx_num_en) begin
      n_strobe++;
      strobe_cyc   = cyc;
      strobe_num   = tx_num;
      wr_at_strobe = wq.size();
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int g, input int j);
    return {8'(g), 8'hA0, 16'(j)};
  endfunction

  task automatic set_num(input int k, input int n);
    nums[k] = n;
    req_num[k*NW +: NW] = NW'(n);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_data"},  64'(tx_data),  64'd0);
    chk({tag, "_numen"}, 64'(tx_num_en), 64'd0);
    chk({tag, "_num"},   64'(tx_num),   64'd0);
    chk({tag, "_rdy"},   64'(req_rdy),  64'd0);
    chk({tag, "_done"},  64'(req_done), 64'd0);
    chk({tag, "_err"},   64'(req_err),  64'd0);
    chk({tag, "_busy"},  64'(busy),     64'd0);
  endtask

  // One packet: wait for a grant, stream the grantee's words, then ack at
  // WAIT_ACK cycle ack_at (ack_at < 0: never ack, expect timeout error).
  task automatic run_packet(input string tag, input int exp_g, input bit toggle,
                            input int ack_at, input bit hold);
    int g, j, guard;
    bit ph, hs;
    logic [NR-1:0] oh;
    wq.delete();
    n_strobe = 0;
    g = -1;
    for (int t = 0; t < 8 && req_rdy == '0; t++) @(negedge clk);
    for (int k = 0; k < NR; k++) if (req_rdy[k]) g = k;
    chk({tag, "_grant"}, 64'(g), 64'(exp_g));
    if (g < 0) g = exp_g;
    oh = '0;
    oh[g] = 1'b1;
    chk({tag, "_rdy_onehot"}, 64'(req_rdy), 64'(oh));
    j = 0; guard = 0; ph = 1'b1;
    while (j <= nums[g] && guard < 400) begin
      req_data[g*DW +: DW] = word(g, j);
      req_vld[g] = toggle ? ph : 1'b1;
      ph = ~ph;
      hs = req_vld[g] && req_rdy[g];
      @(negedge clk);
      guard++;
      if (hs) j++;
    end
    req_vld = '0;
    chk({tag, "_all_words_taken"}, 64'(j), 64'(nums[g] + 1));
    for (int t = 0; t < 8 && !tx_num_en; t++) @(negedge clk);
    chk({tag, "_strobe"}, 64'(tx_num_en), 64'd1);
    chk({tag, "_strobe_num"}, 64'(strobe_num), 64'(nums[g]));
    chk({tag, "_writes_before_strobe"}, 64'(wr_at_strobe), 64'(nums[g] + 1));
    chk({tag, "_strobe_gap"}, 64'(strobe_cyc - last_v), 64'd1);
    chk({tag, "_wcount"}, 64'(wq.size()), 64'(nums[g] + 1));
    for (int i = 0; i < wq.size() && i <= nums[g]; i++)
      chk({tag, "_word"}, 64'(wq[i]), 64'(word(g, i)));
    if (ack_at >= 0) begin
      repeat (ack_at) @(negedge clk);
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      chk({tag, "_done"}, 64'(req_done), 64'(oh));
      chk({tag, "_no_err"}, 64'(req_err), 64'd0);
      if (!hold) req = '0;
      @(negedge clk);
      chk({tag, "_done_1cyc"}, 64'(req_done), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
    end else begin
      repeat (TO - 1) @(negedge clk);
      chk({tag, "_err_not_early"}, 64'(req_err), 64'd0);
      chk({tag, "_busy_wait"}, 64'(busy), 64'd1);
      @(negedge clk);
      chk({tag, "_err"}, 64'(req_err), 64'(oh));
      chk({tag, "_no_done"}, 64'(req_done), 64'd0);
      req = '0;
      @(negedge clk);
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      chk({tag, "_late_ack_done"}, 64'(req_done), 64'd0);
      chk({tag, "_late_ack_busy"}, 64'(busy), 64'd0);
    end
    chk({tag, "_strobe_count"}, 64'(n_strobe), 64'd1);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_num = '0; req_data = '0; req_vld = '0; tx_ack = 1'b0;
    for (int k = 0; k < NR; k++) nums[k] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_quiet("reset");

    // T1: single requester, 4 words
    set_num(0, 3);
    req = 4'b0001;
    run_packet("t1", 0, 1'b0, 3, 1'b0);

    // T2: all requesting, order restarts from 0 after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NR; k++) set_num(k, 1);
    req = 4'b1111;
    run_packet("t2a", 0, 1'b0, 0, 1'b1);
    run_packet("t2b", 1, 1'b0, 2, 1'b1);
    run_packet("t2c", 2, 1'b0, 1, 1'b1);
    run_packet("t2d", 3, 1'b0, 0, 1'b1);
    run_packet("t2e", 0, 1'b0, 4, 1'b0);

    // T3: requester 1 with toggling valid, 8 words
    set_num(1, 7);
    req = 4'b0010;
    run_packet("t3", 1, 1'b1, 0, 1'b0);

    // T4: requester 2, no ack -> timeout, late ack ignored
    set_num(2, 1);
    req = 4'b0100;
    run_packet("t4", 2, 1'b0, -1, 1'b0);

    // T6a: pointer moved past 2 after the error; single-word packet
    set_num(3, 0);
    req = 4'b1111;
    run_packet("t6_num0", 3, 1'b0, 1, 1'b0);

    // T6b: maximum word count, 64 words
    set_num(0, 63);
    req = 4'b0001;
    run_packet("t6_num63", 0, 1'b0, 5, 1'b0);

    // T6c: ack in the same cycle as the timeout
    set_num(1, 2);
    req = 4'b0010;
    run_packet("t6_ack_at_to", 1, 1'b0, TO - 1, 1'b0);

    // T5: reset after 2 of 4 words of requester 0
    set_num(0, 3);
    req = 4'b0001;
    for (int t = 0; t < 8 && req_rdy == '0; t++) @(negedge clk);
    chk("t5_grant", 64'(req_rdy), 64'b0001);
    req_data[0 +: DW] = word(0, 0);
    req_vld[0] = 1'b1;
    @(negedge clk);
    req_data[0 +: DW] = word(0, 1);
    @(negedge clk);
    chk("t5_partial_valid", 64'(tx_valid), 64'd1);
    rst = 1'b1; req = '0; req_vld = '0;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("t5_rst");
    repeat (3) @(negedge clk);
    chk("t5_no_done", 64'(req_done), 64'd0);
    chk("t5_no_err", 64'(req_err), 64'd0);
    for (int k = 0; k < NR; k++) set_num(k, 1);
    req = 4'b1111;
    run_packet("t5_regrant", 0, 1'b0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
